// File: rtl/memory_dp_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory_dp_if : write/read/clear bundle of the dual-port RAM               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface memory_dp_if #(
  parameter int N = 16,
  parameter int A = 8
);
  localparam int L = N / 8;

  logic         clr;
  logic         busy;
  logic         we;
  logic [A-1:0] waddr;
  logic [N-1:0] wdata;
  logic [L-1:0] wbe;
  logic         re;
  logic [A-1:0] raddr;
  logic [N-1:0] rdata;
  logic         rvalid;

  modport master (
    output clr, we, waddr, wdata, wbe, re, raddr,
    input  busy, rdata, rvalid
  );

  modport slave (
    input  clr, we, waddr, wdata, wbe, re, raddr,
    output busy, rdata, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/memory_dp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory_dp : 1W1R synchronous RAM, byte enables, RDW policy, clear sweep   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module memory_dp #(
  parameter int N   = 16,
  parameter int A   = 8,
  parameter int RDW = 0
) (
  input wire         clk,
  input wire         rst_n,
  memory_dp_if.slave bus
);
  localparam int L = N / 8;
  localparam int D = 2 ** A;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [A-1:0] ptr_q, ptr_d;
  logic [N-1:0] mem_q [D];
  logic [N-1:0] rdata_q;
  logic         rvalid_q;

  logic         ready_op;
  logic [N-1:0] old_word;
  logic [N-1:0] merged_word;
  logic [N-1:0] read_word;

  // clr pre-empts any access issued in the same cycle
  assign ready_op = (state_q == READY) && !bus.clr;
  assign old_word = mem_q[bus.waddr];

  for (genvar i = 0; i < L; i++) begin : g_lane
    assign merged_word[8*i +: 8] = bus.wbe[i] ? bus.wdata[8*i +: 8] : old_word[8*i +: 8];
  end

  assign read_word = ((RDW != 0) && bus.we && (bus.waddr == bus.raddr)) ? merged_word
                                                                         : mem_q[bus.raddr];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (bus.clr) begin
          ptr_d = '0;
        end else if (&ptr_q) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + A'(1);
        end
      end
      READY: begin
        if (bus.clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array has no reset so it maps onto plain RAM; the sweep does the zeroing
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else if (ready_op && bus.we) begin
      mem_q[bus.waddr] <= merged_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= ready_op && bus.re;
      if (ready_op && bus.re) begin
        rdata_q <= read_word;
      end
    end
  end

  assign bus.busy   = (state_q == CLEAR);
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
endmodule
`default_nettype wire

// File: tb/tb_memory_dp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_memory_dp : directed bench, read-first and write-first DUTs in step   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_memory_dp;
  localparam int N = 16;
  localparam int A = 4;
  localparam int D = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr   = 1'b0;
  logic         we    = 1'b0;
  logic         re    = 1'b0;
  logic [A-1:0] waddr = '0;
  logic [A-1:0] raddr = '0;
  logic [N-1:0] wdata = '0;
  logic [1:0]   wbe   = '0;

  int tests = 0;
  int fails = 0;
  logic check_en = 1'b0;

  memory_dp_if #(.N(N), .A(A)) bus0 ();
  memory_dp_if #(.N(N), .A(A)) bus1 ();

  assign bus0.clr = clr;  assign bus1.clr = clr;
  assign bus0.we = we;    assign bus1.we = we;
  assign bus0.waddr = waddr; assign bus1.waddr = waddr;
  assign bus0.wdata = wdata; assign bus1.wdata = wdata;
  assign bus0.wbe = wbe;  assign bus1.wbe = wbe;
  assign bus0.re = re;    assign bus1.re = re;
  assign bus0.raddr = raddr; assign bus1.raddr = raddr;

  memory_dp #(.N(N), .A(A), .RDW(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  memory_dp #(.N(N), .A(A), .RDW(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  // Reference: plain array, a countdown of remaining busy cycles, expected read data
  logic [N-1:0] m_mem [D];
  int           m_rem = D;
  logic [N-1:0] m_rd0 = '0;
  logic [N-1:0] m_rd1 = '0;
  logic         m_rv  = 1'b0;
  logic [N-1:0] m_nw;

  function automatic logic [N-1:0] merge(input logic [N-1:0] old, input logic [N-1:0] nw,
                                         input logic [1:0] be);
    logic [N-1:0] r;
    r = old;
    if (be[0]) r[7:0]  = nw[7:0];
    if (be[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  always @(negedge rst_n) begin
    m_rem = D;
    m_rd0 = '0;
    m_rd1 = '0;
    m_rv  = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem = D;
      for (int i = 0; i < D; i++) m_mem[i] = '0;
    end else if (clr) begin
      m_rem = D;
      m_rv  = 1'b0;
      for (int i = 0; i < D; i++) m_mem[i] = '0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      m_rv  = 1'b0;
    end else begin
      m_nw = merge(m_mem[waddr], wdata, wbe);
      m_rv = re;
      if (re) begin
        m_rd0 = m_mem[raddr];
        m_rd1 = (we && waddr == raddr) ? m_nw : m_mem[raddr];
      end
      if (we) m_mem[waddr] = m_nw;
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy0",   N'(bus0.busy),   N'(m_rem > 0));
      chk("busy1",   N'(bus1.busy),   N'(m_rem > 0));
      chk("rvalid0", N'(bus0.rvalid), N'(m_rv));
      chk("rvalid1", N'(bus1.rvalid), N'(m_rv));
      chk("rdata0",  bus0.rdata, m_rd0);
      chk("rdata1",  bus1.rdata, m_rd1);
    end
  end

  task automatic cyc(input logic iclr, input logic iwe, input logic [A-1:0] wa,
                     input logic [N-1:0] wd, input logic [1:0] be,
                     input logic ire, input logic [A-1:0] ra);
    clr = iclr; we = iwe; waddr = wa; wdata = wd; wbe = be; re = ire; raddr = ra;
    @(negedge clk);
    clr = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [N-1:0] d, input logic [1:0] be);
    cyc(1'b0, 1'b1, a, d, be, 1'b0, '0);
  endtask

  task automatic rd(input logic [A-1:0] a);
    cyc(1'b0, 1'b0, '0, '0, 2'b00, 1'b1, a);
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (bus0.busy && n < 100);
    chk(name, N'(n), N'(D));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",   N'(bus0.busy),   16'h0001);
    chk("rst_rvalid", N'(bus0.rvalid), 16'h0000);
    chk("rst_rdata",  bus0.rdata,      16'h0000);

    rst_n = 1'b1;
    count_busy("sweep_len");
    for (int i = 0; i < D; i++) rd(A'(i));
    chk("swept_rdata",  bus0.rdata,      16'h0000);
    chk("swept_rvalid", N'(bus0.rvalid), 16'h0001);

    wr(4'd3, 16'hABCD, 2'b11);
    wr(4'd3, 16'h1200, 2'b10);
    rd(4'd3);
    chk("be_rdata0", bus0.rdata, 16'h12CD);
    chk("be_rdata1", bus1.rdata, 16'h12CD);
    chk("be_rvalid", N'(bus0.rvalid), 16'h0001);
    @(negedge clk);
    chk("idle_rvalid", N'(bus0.rvalid), 16'h0000);
    chk("idle_hold",   bus0.rdata,      16'h12CD);
    wr(4'd3, 16'hFFFF, 2'b00);
    rd(4'd3);
    chk("be_none", bus0.rdata, 16'h12CD);

    wr(4'd5, 16'h1111, 2'b11);
    cyc(1'b0, 1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5);
    chk("rdw_first0", bus0.rdata, 16'h1111);
    chk("rdw_first1", bus1.rdata, 16'h2222);
    rd(4'd5);
    chk("rdw_after0", bus0.rdata, 16'h2222);
    chk("rdw_after1", bus1.rdata, 16'h2222);

    wr(4'd2, 16'hBEEF, 2'b11);
    cyc(1'b0, 1'b1, 4'd7, 16'h00FF, 2'b11, 1'b1, 4'd2);
    chk("indep_rd", bus0.rdata, 16'hBEEF);
    rd(4'd7);
    chk("indep_wr", bus1.rdata, 16'h00FF);

    cyc(1'b1, 1'b1, 4'd1, 16'h5555, 2'b11, 1'b0, '0);
    chk("clr_busy", N'(bus0.busy), 16'h0001);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 4'd9, 16'h7777, 2'b11, 1'b1, 4'd3);
    chk("busy_rvalid", N'(bus0.rvalid), 16'h0000);
    cyc(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, '0);
    count_busy("clr_restart_len");
    rd(4'd1);
    chk("clr_drop_wr", bus0.rdata, 16'h0000);
    rd(4'd9);
    chk("busy_drop_wr", bus1.rdata, 16'h0000);

    wr(4'd4, 16'h4444, 2'b11);
    re = 1'b1; raddr = 4'd4;
    repeat (3) @(negedge clk);
    chk("b2b_rdata", bus0.rdata, 16'h4444);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rdata",  bus0.rdata,      16'h0000);
    chk("async_rvalid", N'(bus1.rvalid), 16'h0000);
    chk("async_busy",   N'(bus0.busy),   16'h0001);
    re = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy("resweep_len");
    rd(4'd4);
    chk("resweep_rd", bus0.rdata, 16'h0000);

    repeat (2) @(negedge clk);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/memory_dp.md
# memory_dp

Simple dual-port synchronous RAM with one write port and one read port. It generalises the single-port memory in data width, address width, per-byte write enables and a selectable read-during-write policy. A built-in clear sequencer zeroes the whole array after reset or on request. It is the storage primitive for register files, FIFOs and scratchpads that need a write and a read in the same cycle.

## Interface
- N, 16: data width in bits; must be a multiple of 8; L = N/8 byte lanes.
- A, 8: address width; depth D = 2**A words.
- RDW, 0: read-during-write policy for the same address. 0 = read-first (old data). 1 = write-first (new merged data).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous request to re-zero the array.
- busy  out  1  high while the clear sweep runs.
- we  in  1  write request.
- waddr  in  A  write address.
- wdata  in  N  write data.
- wbe  in  L  byte enables; bit i selects wdata[8i+7:8i].
- re  in  1  read request.
- raddr  in  A  read address.
- rdata  out  N  registered read data.
- rvalid  out  1  high for one cycle when rdata carries a fresh read.

## Operation
- Reset is asynchronous and active-low. While rst_n=0: state=CLEAR, ptr=0, busy=1, rdata=0, rvalid=0. Array contents are not touched asynchronously.
- FSM states are CLEAR and READY.
- CLEAR, on each edge:
  - mem[ptr] <= 0, then ptr <= ptr+1.
  - On the edge that writes ptr=D-1: state <= READY, ptr <= 0.
  - we and re are ignored; rvalid=0; rdata holds its value.
  - clr=1 restarts the sweep with ptr <= 0.
- READY with clr=1: state <= CLEAR and ptr <= 0 on the next edge. Any we/re in that cycle is dropped and rvalid stays 0. clr has priority over both.
- READY with we=1: lanes with wbe[i]=1 update and the other lanes keep their old bytes. we=1 with wbe=0 is a no-op.
- READY with re=1: rdata <= mem[raddr] and rvalid <= 1.
- READY with re=0: rvalid <= 0 and rdata holds its last value.
- Same-cycle we=1, re=1, waddr=raddr:
  - RDW=0: rdata = the word before the write.
  - RDW=1: rdata = the merged word (new bytes in enabled lanes, old bytes elsewhere).
  - The array is updated identically in both modes.
- Different addresses: the write and the read are fully independent.
- Address wrap: addresses are exactly A bits, so no out-of-range access is possible.
- Reset asserted mid-sweep or mid-operation aborts immediately. The sweep restarts from address 0 after release.

## Timing
- Sweep length: exactly D cycles. busy=1 from reset release through the D-th edge; busy=0 after it.
- busy is a registered output, high exactly when state=CLEAR.
- clr sampled at edge k: busy=1 from after edge k through edge k+D.
- Write: visible to a read issued on the following cycle. For a same-cycle read, RDW applies.
- Read latency is 1: re sampled at edge k puts rdata and rvalid valid after edge k. rvalid deasserts after edge k+1 unless re is asserted again.
- Back-to-back reads every cycle give rvalid=1 continuously.
- Throughput: one write plus one read per cycle in READY.

## Test plan
All scenarios use N=16, A=4 (D=16).
- Reset and sweep: pulse rst_n low, release, count cycles. Require busy=1 for exactly 16 edges, rvalid=0 throughout, and every address reading 0x0000 afterwards.
- Byte enables:
  - write 0xABCD to addr 3 with wbe=11, then 0x1200 with wbe=10, then read addr 3: rdata=0x12CD, rvalid=1 one cycle after re.
  - we=1 with wbe=00 leaves addr 3 at 0x12CD.
- Read-during-write: addr 5 holds 0x1111; issue we=1, wbe=11, wdata=0x2222 and re=1 to addr 5 in the same cycle.
  - RDW=0: rdata=0x1111.
  - RDW=1: rdata=0x2222.
  - Either mode: the next read of addr 5 returns 0x2222.
- Independent ports: write 0x00FF to addr 7 while reading addr 2 (holds 0xBEEF) in the same cycle. Require rdata=0xBEEF, then a read of addr 7 returns 0x00FF.
- clr priority and restart:
  - In READY, assert clr with we=1 to addr 1: the write is dropped and busy rises.
  - Assert clr again at sweep cycle 8: busy lasts 16 more cycles.
  - Reads and writes issued while busy have no effect; rvalid stays 0.
- Reset mid-operation: drop rst_n during back-to-back reads. Require rdata=0 and rvalid=0 immediately (asynchronously), busy=1, and a full 16-cycle sweep after release.
